alu_arbiter: RTL and testbench

- Shares one combinational ALU instance between two requesters (e.g. main pipeline EX stage and a multi-cycle helper unit).
- Arbitrates round-robin and latches the granted operands/opcode into registers that drive the shared ALU.
- Captures the ALU result into a register and returns it to the winning requester over a valid/ready handshake.
- Sits between the requesters and the ALU's SrcA/SrcB/Operation/ALUResult pins; the ALU itself is instantiated outside.

---
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Operands are registered toward the ALU and the result is returned over valid/ready.
module alu_arbiter #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned OPCODE_LENGTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,

   input  logic                     req0_valid,
   output logic                     req0_ready,
   input  logic [DATA_WIDTH-1:0]    req0_srca,
   input  logic [DATA_WIDTH-1:0]    req0_srcb,
   input  logic [OPCODE_LENGTH-1:0] req0_op,

   input  logic                     req1_valid,
   output logic                     req1_ready,
   input  logic [DATA_WIDTH-1:0]    req1_srca,
   input  logic [DATA_WIDTH-1:0]    req1_srcb,
   input  logic [OPCODE_LENGTH-1:0] req1_op,

   output logic                     rsp0_valid,
   input  logic                     rsp0_ready,
   output logic                     rsp1_valid,
   input  logic                     rsp1_ready,
   output logic [DATA_WIDTH-1:0]    rsp_result,

   output logic [DATA_WIDTH-1:0]    alu_srca,
   output logic [DATA_WIDTH-1:0]    alu_srcb,
   output logic [OPCODE_LENGTH-1:0] alu_op,
   input  logic [DATA_WIDTH-1:0]    alu_result,

   output logic                     busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e                   state_q, state_d;
   logic                     rr_last_q, rr_last_d;
   logic                     owner_q, owner_d;
   logic [DATA_WIDTH-1:0]    srca_q, srca_d;
   logic [DATA_WIDTH-1:0]    srcb_q, srcb_d;
   logic [OPCODE_LENGTH-1:0] op_q, op_d;
   logic [DATA_WIDTH-1:0]    result_q, result_d;

   logic grant_c;
   logic accept_c;
   logic rsp_hs_c;

   // Grant: lone requester wins; on contention the one not served last wins.
   always_comb begin
      grant_c = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_c = ~rr_last_q;
      end else if (req1_valid) begin
         grant_c = 1'b1;
      end
   end

   assign accept_c = (state_q == IDLE) && !reset && (req0_valid || req1_valid);
   assign rsp_hs_c = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_c) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_hs_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: operand latch on accept, result capture in EXEC.
   always_comb begin
      rr_last_d = rr_last_q;
      owner_d   = owner_q;
      srca_d    = srca_q;
      srcb_d    = srcb_q;
      op_d      = op_q;
      result_d  = result_q;
      if (accept_c) begin
         owner_d = grant_c;
         srca_d  = grant_c ? req1_srca : req0_srca;
         srcb_d  = grant_c ? req1_srcb : req0_srcb;
         op_d    = grant_c ? req1_op   : req0_op;
      end
      if (state_q == EXEC) begin
         result_d = alu_result;
      end
      if (rsp_hs_c) begin
         rr_last_d = owner_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_last_q <= 1'b1;
         owner_q   <= 1'b0;
         srca_q    <= '0;
         srcb_q    <= '0;
         op_q      <= '0;
         result_q  <= '0;
      end else begin
         rr_last_q <= rr_last_d;
         owner_q   <= owner_d;
         srca_q    <= srca_d;
         srcb_q    <= srcb_d;
         op_q      <= op_d;
         result_q  <= result_d;
      end
   end

   // Output logic
   always_comb begin
      req0_ready = accept_c && !grant_c;
      req1_ready = accept_c && grant_c;
      rsp0_valid = (state_q == RESP) && !owner_q;
      rsp1_valid = (state_q == RESP) && owner_q;
      busy       = (state_q != IDLE);
   end

   assign rsp_result = result_q;
   assign alu_srca   = srca_q;
   assign alu_srcb   = srcb_q;
   assign alu_op     = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: drivers push expected results, a negedge
// monitor tracks an abstract busy/owner model and checks grants, responses and data.
module tb_alu_arbiter;
   localparam int unsigned DW = 32;
   localparam int unsigned OL = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [DW-1:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
   logic [OL-1:0] req0_op, req1_op;
   logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [DW-1:0] rsp_result, alu_srca, alu_srcb, alu_result;
   logic [OL-1:0] alu_op;
   logic          busy;

   always #5 clk = ~clk;

   alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_srca(req0_srca),
      .req0_srcb(req0_srcb), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_srca(req1_srca),
      .req1_srcb(req1_srcb), .req1_op(req1_op),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp_result(rsp_result),
      .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op),
      .alu_result(alu_result), .busy(busy)
   );

   // Behavioural ALU: the few operations exercised here, anything else yields 0.
   function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [OL-1:0] op);
      case (op)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0011: return a - b;
         4'b0100: return a ^ b;
         4'b1001: return b;
         default: return '0;
      endcase
   endfunction

   always_comb alu_result = ref_alu(alu_srca, alu_srcb, alu_op);

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   logic [DW-1:0] exp0_q[$];
   logic [DW-1:0] exp1_q[$];

   // Response-ready generators: percentage chance of ready each cycle.
   int pct0 = 100;
   int pct1 = 100;
   always @(posedge clk) begin
      #1;
      rsp0_ready = ($urandom_range(0, 99) < pct0);
      rsp1_ready = ($urandom_range(0, 99) < pct1);
   end

   // Abstract model: one op in flight, response two cycles after accept.
   logic m_free = 1'b1, m_last = 1'b1, m_owner = 1'b0, rst_prev = 1'b0;
   logic m_g, e_r0, e_r1, resp_phase, hs;
   int   cyc = 0, acc_cyc = 0;

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         chk("ready0_in_reset", DW'(req0_ready), DW'(1'b0));
         chk("ready1_in_reset", DW'(req1_ready), DW'(1'b0));
         if (rst_prev) begin
            chk("busy_after_reset", DW'(busy), DW'(1'b0));
            chk("rsp0_valid_after_reset", DW'(rsp0_valid), DW'(1'b0));
            chk("rsp1_valid_after_reset", DW'(rsp1_valid), DW'(1'b0));
            chk("alu_srca_after_reset", alu_srca, '0);
            chk("alu_srcb_after_reset", alu_srcb, '0);
            chk("alu_op_after_reset", DW'(alu_op), '0);
            chk("rsp_result_after_reset", rsp_result, '0);
         end
         m_free = 1'b1;
         m_last = 1'b1;
         exp0_q.delete();
         exp1_q.delete();
      end else begin
         m_g        = (req0_valid && req1_valid) ? !m_last : req1_valid;
         e_r0       = m_free && req0_valid && !m_g;
         e_r1       = m_free && req1_valid && m_g;
         resp_phase = !m_free && (cyc >= acc_cyc + 2);
         chk("req0_ready", DW'(req0_ready), DW'(e_r0));
         chk("req1_ready", DW'(req1_ready), DW'(e_r1));
         chk("busy", DW'(busy), DW'(!m_free));
         chk("rsp0_valid", DW'(rsp0_valid), DW'(resp_phase && !m_owner));
         chk("rsp1_valid", DW'(rsp1_valid), DW'(resp_phase && m_owner));
         if (resp_phase) begin
            hs = m_owner ? rsp1_ready : rsp0_ready;
            if (m_owner ? (exp1_q.size() == 0) : (exp0_q.size() == 0)) begin
               chk("scoreboard_nonempty", DW'(1'b0), DW'(1'b1));
            end else begin
               chk(m_owner ? "rsp_result_req1" : "rsp_result_req0", rsp_result,
                   m_owner ? exp1_q[0] : exp0_q[0]);
               if (hs) begin
                  if (m_owner) void'(exp1_q.pop_front());
                  else         void'(exp0_q.pop_front());
               end
            end
            if (hs) begin
               m_free = 1'b1;
               m_last = m_owner;
            end
         end else if (m_free && (req0_valid || req1_valid)) begin
            m_free  = 1'b0;
            m_owner = m_g;
            acc_cyc = cyc;
         end
      end
      rst_prev = reset;
   end

   // Present one operation and hold it until accepted; expected result is queued on accept.
   task automatic send(input int n, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [OL-1:0] op);
      bit done = 1'b0;
      if (n == 0) begin
         req0_srca = a; req0_srcb = b; req0_op = op; req0_valid = 1'b1;
      end else begin
         req1_srca = a; req1_srcb = b; req1_op = op; req1_valid = 1'b1;
      end
      for (int k = 0; k < 500 && !done; k++) begin
         @(negedge clk);
         if (!reset && ((n == 0) ? req0_ready : req1_ready)) begin
            if (n == 0) exp0_q.push_back(ref_alu(a, b, op));
            else        exp1_q.push_back(ref_alu(a, b, op));
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (n == 0) req0_valid = 1'b0;
      else        req1_valid = 1'b0;
      if (!done) chk("send_accept_timeout", DW'(1'b0), DW'(1'b1));
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (m_free) done = 1'b1;
      end
      @(posedge clk); #1;
      if (!done) chk("idle_timeout", DW'(1'b0), DW'(1'b1));
   endtask

   task automatic pulse_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic rand_driver(input int n, input int count);
      logic [OL-1:0] op;
      for (int i = 0; i < count; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         case ($urandom_range(0, 7))
            0: op = 4'b0000;
            1: op = 4'b0001;
            2: op = 4'b0010;
            3: op = 4'b0011;
            4: op = 4'b0100;
            5: op = 4'b1001;
            6: op = 4'b1111;
            default: op = OL'($urandom);
         endcase
         send(n, $urandom, $urandom, op);
      end
   endtask

   initial begin
      reset      = 1'b1;
      req0_valid = 1'b0; req0_srca = '0; req0_srcb = '0; req0_op = '0;
      req1_valid = 1'b0; req1_srca = '0; req1_srcb = '0; req1_op = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // No requests: stays idle with readies low.
      repeat (10) @(posedge clk);
      #1;

      send(0, 32'd5, 32'd7, 4'b0010);
      wait_idle();

      // Contention straight out of reset: 0, 1, then 0 again.
      pulse_reset(2);
      fork
         begin
            send(0, 32'd10, 32'd3, 4'b0011);
            send(0, 32'd10, 32'd3, 4'b0011);
         end
         send(1, 32'hF0, 32'h3C, 4'b0000);
      join
      wait_idle();

      // Back-pressure on req1 while req0 raises and withdraws its valid.
      pct1 = 0;
      send(1, 32'd0, 32'h1234_5000, 4'b1001);
      req0_srca = 32'd1; req0_srcb = 32'd2; req0_op = 4'b0010; req0_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1 req0_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 pct1 = 100;
      wait_idle();

      // Back-pressure on req0 while req1 raises and withdraws its valid.
      pct0 = 0;
      send(0, 32'd9, 32'd4, 4'b0100);
      req1_srca = 32'd3; req1_srcb = 32'd3; req1_op = 4'b0010; req1_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1 req1_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 pct0 = 100;
      wait_idle();

      send(0, 32'd0, 32'd1, 4'b0011);
      wait_idle();
      send(0, 32'hDEAD_BEEF, 32'h1, 4'b1111);
      wait_idle();

      // Reset during EXEC, then during RESP.
      send(1, 32'd3, 32'd4, 4'b0010);
      pulse_reset(2);
      pct0 = 0;
      send(0, 32'd6, 32'd6, 4'b0010);
      repeat (2) @(posedge clk);
      #1 pulse_reset(2);
      pct0 = 100;
      fork
         send(0, 32'd1, 32'd1, 4'b0010);
         send(1, 32'd8, 32'd1, 4'b0011);
      join
      wait_idle();

      // Random traffic with random response back-pressure.
      pct0 = 70;
      pct1 = 60;
      fork
         rand_driver(0, 40);
         rand_driver(1, 40);
      join
      pct0 = 100;
      pct1 = 100;
      wait_idle();
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
